// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth and optional first-word-fall-through output.
// Write-to-read latency: 1 edge (standard) or 0 edges (FWFT). No backpressure: writes are dropped when full, reads are ignored when empty, and both set sticky flags.
module sync_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       clr,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       rdEn,
  output logic [WIDTH-1:0]           rdData,
  output logic                       full,
  output logic                       empty,
  output logic                       almostFull,
  output logic                       almostEmpty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    cnt;
  logic             wrAcc;
  logic             rdAcc;

  // Flags decode the registered count only, so they never glitch between edges.
  assign full        = (cnt == CW'(DEPTH));
  assign empty       = (cnt == '0);
  assign almostFull  = (cnt >= CW'(AFULL_TH));
  assign almostEmpty = (cnt <= CW'(AEMPTY_TH));
  assign count       = cnt;

  assign wrAcc = wrEn && !full && !clr;
  assign rdAcc = rdEn && !empty && !clr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrEn && full)  overflow  <= 1'b1;
      if (rdEn && empty) underflow <= 1'b1;
      // Explicit wrap so non-power-of-two depths never address past the last entry.
      if (wrAcc) wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
      if (rdAcc) rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
      case ({wrAcc, rdAcc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrAcc) mem[wrPtr] <= wrData;
  end

  generate
    if (FWFT != 0) begin : gFwft
      // Head is driven to zero while empty so reset and flush present a clean bus.
      assign rdData = empty ? '0 : mem[rdPtr];
    end else begin : gStd
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)      rdData <= '0;
        else if (clr)   rdData <= '0;
        else if (rdAcc) rdData <= mem[rdPtr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and checks both against a queue model.
module tb_sync_fifo_flex;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         clr = 1'b0;
  logic         wrEn = 1'b0;
  logic         rdEn = 1'b0;
  logic [W-1:0] wrData = '0;

  logic [W-1:0] rdData0, rdData1;
  logic         full0, empty0, aFull0, aEmpty0, ovf0, unf0;
  logic         full1, empty1, aFull1, aEmpty1, ovf1, unf1;
  logic [2:0]   count0, count1;

  int tests = 0;
  int fails = 0;

  // Reference model: plain queue plus sticky bits and the last popped word.
  logic [W-1:0] q[$];
  bit           mOvf = 0;
  bit           mUnf = 0;
  logic [W-1:0] mRd  = '0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) dutStd (
    .clk(clk), .rstN(rstN), .clr(clr), .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn),
    .rdData(rdData0), .full(full0), .empty(empty0), .almostFull(aFull0),
    .almostEmpty(aEmpty0), .count(count0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) dutFwft (
    .clk(clk), .rstN(rstN), .clr(clr), .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn),
    .rdData(rdData1), .full(full1), .empty(empty1), .almostFull(aFull1),
    .almostEmpty(aEmpty1), .count(count1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    int n;
    n = q.size();
    chk({tag, " count"},       32'(count0),  32'(n));
    chk({tag, " full"},        32'(full0),   32'(n == D));
    chk({tag, " empty"},       32'(empty0),  32'(n == 0));
    chk({tag, " almostFull"},  32'(aFull0),  32'(n >= AF));
    chk({tag, " almostEmpty"}, 32'(aEmpty0), 32'(n <= AE));
    chk({tag, " overflow"},    32'(ovf0),    32'(mOvf));
    chk({tag, " underflow"},   32'(unf0),    32'(mUnf));
    chk({tag, " rdData std"},  32'(rdData0), 32'(mRd));
    chk({tag, " fwft count"},  32'(count1),  32'(n));
    chk({tag, " fwft empty"},  32'(empty1),  32'(n == 0));
    chk({tag, " fwft ovf"},    32'(ovf1),    32'(mOvf));
    chk({tag, " fwft unf"},    32'(unf1),    32'(mUnf));
    if (n != 0) chk({tag, " fwft head"}, 32'(rdData1), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic step(input string tag, input bit we, input logic [W-1:0] wd, input bit re, input bit cl);
    bit isFull, isEmpty;
    wrEn = we; wrData = wd; rdEn = re; clr = cl;
    @(posedge clk);
    isFull  = (q.size() == D);
    isEmpty = (q.size() == 0);
    if (cl) begin
      q.delete(); mOvf = 0; mUnf = 0; mRd = '0;
    end else begin
      if (we && isFull)  mOvf = 1;
      if (re && isEmpty) mUnf = 1;
      if (re && !isEmpty) mRd = q.pop_front();
      if (we && !isFull) q.push_back(wd);
    end
    #1;
    checkAll(tag);
    wrEn = 0; rdEn = 0; clr = 0;
  endtask

  initial begin
    #2;
    checkAll("reset");
    @(negedge clk);
    rstN = 1'b1;

    // Fill in standard mode, then overflow, then drain in order.
    for (int i = 1; i <= 5; i++) step("fill", 1, 8'(i * 8'h11), 0, 0);
    step("overflow", 1, 8'h66, 0, 0);
    for (int i = 0; i < 5; i++) step("drain", 0, 8'h00, 1, 0);

    // Pointer wrap at steady occupancy 2.
    step("pre2a", 1, 8'h01, 0, 0);
    step("pre2b", 1, 8'h02, 0, 0);
    for (int i = 0; i < 12; i++) step("wrap", 1, 8'($urandom), 1, 0);
    step("clr0", 0, 8'h00, 0, 1);

    // Simultaneous read/write on empty and on full.
    step("simEmpty", 1, 8'hA5, 1, 0);
    for (int i = 0; i < 4; i++) step("refill", 1, 8'($urandom), 0, 0);
    step("simFull", 1, 8'hEE, 1, 0);
    for (int i = 0; i < 4; i++) step("drain2", 0, 8'h00, 1, 0);
    step("clr1", 0, 8'h00, 0, 1);

    // Fall-through visibility without a read, then pop.
    step("fwftWr", 1, 8'h3C, 0, 0);
    step("fwftRd", 0, 8'h00, 1, 0);

    // Flush at count 3 with overflow set, write in the same cycle must be dropped.
    for (int i = 0; i < 6; i++) step("ovfFill", 1, 8'(8'h40 + i), 0, 0);
    step("toThreeA", 0, 8'h00, 1, 0);
    step("toThreeB", 0, 8'h00, 1, 0);
    step("flushWr", 1, 8'h99, 0, 1);
    step("postFlush", 1, 8'h5A, 0, 0);
    step("postFlushRd", 0, 8'h00, 1, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      step("rand", bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));

    // Asynchronous reset in the middle of traffic, checked before any further edge.
    for (int i = 0; i < 3; i++) step("preRst", 1, 8'($urandom), 0, 0);
    step("preRstRd", 0, 8'h00, 1, 0);
    step("preRstOvf", 1, 8'h77, 1, 0);
    #1;
    rstN = 1'b0;
    q.delete(); mOvf = 0; mUnf = 0; mRd = '0;
    #1;
    checkAll("asyncRst");
    @(negedge clk);
    rstN = 1'b1;
    step("afterRst", 1, 8'hC3, 0, 0);
    step("afterRstRd", 0, 8'h00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Single-clock parametrised FIFO, the successor to our dual-clock FIFO for blocks where producer and consumer share a clock. It adds:
- arbitrary (non-power-of-two) depth
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags
- synchronous flush

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of storage entries; any integer >= 2.
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: almostFull asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2: almostEmpty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- clk  input  1  single clock; all state updates on the rising edge.
- rstN  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush; highest priority after reset.
- wrEn  input  1  write request.
- wrData  input  WIDTH  write data.
- rdEn  input  1  read (pop) request.
- rdData  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almostFull  output  1  count >= AFULL_TH.
- almostEmpty  output  1  count <= AEMPTY_TH.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a write while full.
- underflow  output  1  sticky; set by a read while empty.

## Operation
**Storage and pointers**
- Storage is DEPTH words, addressed 0..DEPTH-1.
- wrPtr and rdPtr are $clog2(DEPTH) bits wide.
- Each pointer increments on its accepted operation. At DEPTH-1 it wraps to 0 by explicit compare; there is no power-of-two wrap.
- full and empty come from the count register, not from pointer comparison.

**Accepting operations**
- Write accepted = wrEn && !full. It stores wrData at wrPtr.
- Read accepted = rdEn && !empty. It advances rdPtr.
- Rejected operations leave pointers, count and memory unchanged.

**Count update**
- Accepted write only: count + 1.
- Accepted read only: count - 1.
- Both accepted in the same cycle: count unchanged.

**Boundary cases**
- When empty, wrEn && rdEn: only the write is accepted, and underflow sets.
- When full, wrEn && rdEn: only the read is accepted, and overflow sets.
- A write is never accepted while full, even with a concurrent read.

**Error flags and flush**
- overflow sets on wrEn && full; underflow sets on rdEn && empty.
- Both are sticky until clr or reset.
- clr: wrPtr, rdPtr, count, overflow, underflow and rdData are cleared to 0. Memory contents are not cleared.
- clr overrides any wrEn/rdEn asserted in the same cycle.

**Read modes**
- FWFT=0: on an accepted read, rdData is loaded from mem[rdPtr] at that edge. Otherwise rdData holds its value.
- FWFT=1: rdData = mem[rdPtr] combinationally. It is valid whenever empty == 0 and is don't-care when empty. An accepted read pops the head, and the next word appears in the same cycle as the pointer update.

**Flag generation**
- full, empty, almostFull and almostEmpty are combinational decodes of the count register. They are therefore glitch-free relative to clk.

## Timing
- Reset values: count 0, empty 1, full 0, almostEmpty 1, almostFull 0, overflow 0, underflow 0, rdData 0, wrPtr 0, rdPtr 0.
- Write latency: a write accepted at edge N updates count and clears empty at edge N.
  - FWFT=1: the word is visible on rdData after edge N.
  - FWFT=0: the earliest read is at edge N+1, with data valid after edge N+1.
- Flags and count change only on clk edges, or asynchronously on rstN assertion.
- Reset mid-operation: all state returns to the reset values immediately. Normal operation resumes on the first edge after rstN deasserts.
- Throughput: one write and one read per cycle, sustained at any occupancy 1..DEPTH-1.

## Test plan
All scenarios use WIDTH=8, DEPTH=5, AFULL_TH=4, AEMPTY_TH=1.
- **Fill, FWFT=0:** write 0x11..0x55, one per cycle.
  - almostFull at count 4; full at count 5.
  - A 6th write sets overflow; count stays 5.
  - Five reads return 0x11..0x55 in order; then empty = 1.
- **Wrap-around:** run 12 write/read pairs at occupancy 2.
  - Pointers wrap 4 -> 0 without data loss.
  - count stays 2 throughout; data order is preserved.
- **Simultaneous at boundaries:**
  - Empty FIFO, wrEn and rdEn with 0xA5: count becomes 1 and underflow sets.
  - Full FIFO, wrEn and rdEn: count becomes 4, overflow sets, and the written word is absent from the read stream.
- **FWFT=1:** write 0x3C at edge N.
  - rdData = 0x3C and empty = 0 after edge N, with no read issued.
  - A read then pops it; empty = 1.
- **Flush and reset:**
  - At count 3 with overflow set, pulse clr together with wrEn: count 0, overflow 0, rdData 0, and no write stored.
  - Drop rstN mid-stream: all outputs reach reset values without waiting for a clk edge.
